// File: rtl/sdram_cmd_checker_pkg.sv
// Shared definitions for the SDRAM command-bus checker: pin encodings, command and
// error codes, init states and default timing limits.
package sdram_cmd_checker_pkg;

  localparam int unsigned CNT_W = 14;

  localparam int unsigned DEF_T_PWRUP = 13333;
  localparam int unsigned DEF_T_RP    = 3;
  localparam int unsigned DEF_T_RRC   = 9;
  localparam int unsigned DEF_T_RCD   = 3;
  localparam int unsigned DEF_T_MRD   = 2;
  localparam int unsigned DEF_T_DAL   = 5;
  localparam int unsigned DEF_T_REFI  = 1040;

  // {CKE,CS,RAS,CAS,WE}
  localparam logic [4:0] PIN_NOP  = 5'b10111;
  localparam logic [4:0] PIN_ACT  = 5'b10011;
  localparam logic [4:0] PIN_WR   = 5'b10100;
  localparam logic [4:0] PIN_RD   = 5'b10101;
  localparam logic [4:0] PIN_BSTP = 5'b10110;
  localparam logic [4:0] PIN_PR   = 5'b10010;
  localparam logic [4:0] PIN_AR   = 5'b10001;
  localparam logic [4:0] PIN_LMR  = 5'b10000;

  typedef enum logic [2:0] {
    CMD_NOP  = 3'd0,
    CMD_ACT  = 3'd1,
    CMD_WR   = 3'd2,
    CMD_RD   = 3'd3,
    CMD_BSTP = 3'd4,
    CMD_PR   = 3'd5,
    CMD_AR   = 3'd6,
    CMD_LMR  = 3'd7
  } cmd_e;

  typedef enum logic [3:0] {
    ERR_NONE       = 4'd0,
    ERR_INIT_ORDER = 4'd1,
    ERR_TRP        = 4'd2,
    ERR_TRRC       = 4'd3,
    ERR_TRCD       = 4'd4,
    ERR_TMRD       = 4'd5,
    ERR_ROW_STATE  = 4'd6,
    ERR_ROW_OPEN   = 4'd7,
    ERR_TDAL       = 4'd8,
    ERR_REFI       = 4'd9
  } err_e;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_W_PR,
    ST_W_AR0,
    ST_W_AR1,
    ST_W_LMR,
    ST_READY
  } init_state_e;

  // Deselected (CS=1) or clock-suspended (CKE=0) pins match no pattern and fall to NOP.
  function automatic cmd_e decode_cmd(input logic [4:0] pins);
    cmd_e c;
    c = CMD_NOP;
    case (pins)
      PIN_NOP:  c = CMD_NOP;
      PIN_ACT:  c = CMD_ACT;
      PIN_WR:   c = CMD_WR;
      PIN_RD:   c = CMD_RD;
      PIN_BSTP: c = CMD_BSTP;
      PIN_PR:   c = CMD_PR;
      PIN_AR:   c = CMD_AR;
      PIN_LMR:  c = CMD_LMR;
      default:  c = CMD_NOP;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/sdram_cmd_checker_gap_cnt.sv
// Saturating cycle counter: loads 1 on the cycle after its command, then counts up
// and sticks at all-ones.
module sdram_gap_cnt
  import sdram_cmd_checker_pkg::*;
#(
  parameter int unsigned W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= W'(1);
    end else if (cnt != '1) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sdram_cmd_checker.sv
// Passive SDRAM command-bus monitor: decodes each sampled command, follows the init
// sequence and open-row state, and flags ordering/timing violations.
module sdram_cmd_checker
  import sdram_cmd_checker_pkg::*;
#(
  parameter int unsigned T_PWRUP = DEF_T_PWRUP,
  parameter int unsigned T_RP    = DEF_T_RP,
  parameter int unsigned T_RRC   = DEF_T_RRC,
  parameter int unsigned T_RCD   = DEF_T_RCD,
  parameter int unsigned T_MRD   = DEF_T_MRD,
  parameter int unsigned T_DAL   = DEF_T_DAL,
  parameter int unsigned T_REFI  = DEF_T_REFI
) (
  input  logic       sclk,
  input  logic       rst_n,
  input  logic       CKE,
  input  logic       CS,
  input  logic       RAS,
  input  logic       CAS,
  input  logic       WE,
  output logic       cmd_vld,
  output logic [2:0] cmd_code,
  output logic       init_done,
  output logic       row_open,
  output logic       err_pulse,
  output logic [3:0] err_code,
  output logic       err_sticky
);

  cmd_e             cmd;
  init_state_e      state;
  logic [CNT_W-1:0] pwrup_cnt;
  logic [CNT_W-1:0] pr_cnt, ar_cnt, act_cnt, lmr_cnt, wr_cnt, refi_cnt;
  logic             refi_armed;
  logic             order_ok, gap_chk, rw;
  logic [9:1]       viol;
  logic [3:0]       err_sel;

  sdram_gap_cnt #(.W(CNT_W)) u_pr_cnt   (.clk(sclk), .rst_n(rst_n), .clr(cmd == CMD_PR),  .cnt(pr_cnt));
  sdram_gap_cnt #(.W(CNT_W)) u_ar_cnt   (.clk(sclk), .rst_n(rst_n), .clr(cmd == CMD_AR),  .cnt(ar_cnt));
  sdram_gap_cnt #(.W(CNT_W)) u_act_cnt  (.clk(sclk), .rst_n(rst_n), .clr(cmd == CMD_ACT), .cnt(act_cnt));
  sdram_gap_cnt #(.W(CNT_W)) u_lmr_cnt  (.clk(sclk), .rst_n(rst_n), .clr(cmd == CMD_LMR), .cnt(lmr_cnt));
  sdram_gap_cnt #(.W(CNT_W)) u_wr_cnt   (.clk(sclk), .rst_n(rst_n), .clr(cmd == CMD_WR),  .cnt(wr_cnt));
  sdram_gap_cnt #(.W(CNT_W)) u_refi_cnt (.clk(sclk), .rst_n(rst_n), .clr(cmd == CMD_AR),  .cnt(refi_cnt));

  always_comb begin
    cmd     = decode_cmd({CKE, CS, RAS, CAS, WE});
    rw      = (cmd == CMD_RD) || (cmd == CMD_WR);
    // BSTP carries no timing or row obligations once the device is ready.
    gap_chk = (cmd != CMD_NOP) && (cmd != CMD_BSTP);

    order_ok = 1'b1;
    case (state)
      ST_PWRUP:           order_ok = (cmd == CMD_NOP);
      ST_W_PR:            order_ok = cmd inside {CMD_NOP, CMD_PR};
      ST_W_AR0, ST_W_AR1: order_ok = cmd inside {CMD_NOP, CMD_AR};
      ST_W_LMR:           order_ok = cmd inside {CMD_NOP, CMD_LMR};
      default:            order_ok = 1'b1;
    endcase

    viol                 = '0;
    viol[ERR_INIT_ORDER] = !order_ok;
    viol[ERR_TRP]        = gap_chk && (pr_cnt  < CNT_W'(T_RP));
    viol[ERR_TRRC]       = gap_chk && (ar_cnt  < CNT_W'(T_RRC));
    viol[ERR_TRCD]       = rw && (act_cnt < CNT_W'(T_RCD));
    viol[ERR_TMRD]       = gap_chk && (lmr_cnt < CNT_W'(T_MRD));
    viol[ERR_ROW_STATE]  = (state == ST_READY) &&
                           ((rw && !row_open) || ((cmd == CMD_LMR) && row_open));
    viol[ERR_ROW_OPEN]   = (state == ST_READY) && (cmd == CMD_ACT) && row_open;
    viol[ERR_TDAL]       = (cmd == CMD_PR) && (wr_cnt < CNT_W'(T_DAL));
    viol[ERR_REFI]       = (state == ST_READY) && refi_armed &&
                           (refi_cnt == CNT_W'(T_REFI + 1));

    err_sel = '0;
    for (int unsigned i = 1; i <= 9; i++) begin
      if (viol[i] && (err_sel == '0)) err_sel = 4'(i);
    end
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_PWRUP;
      pwrup_cnt  <= '0;
      refi_armed <= 1'b0;
      cmd_vld    <= 1'b0;
      cmd_code   <= '0;
      init_done  <= 1'b0;
      row_open   <= 1'b0;
      err_pulse  <= 1'b0;
      err_code   <= '0;
      err_sticky <= 1'b0;
    end else begin
      cmd_vld   <= (cmd != CMD_NOP);
      cmd_code  <= cmd;
      err_pulse <= |viol;
      if ((|viol) && !err_sticky) begin
        err_code   <= err_sel;
        err_sticky <= 1'b1;
      end

      if (cmd == CMD_AR)      refi_armed <= 1'b1;
      else if (viol[ERR_REFI]) refi_armed <= 1'b0;

      // A correctly ordered command advances init even if it also broke a gap.
      case (state)
        ST_PWRUP: begin
          if (pwrup_cnt == CNT_W'(T_PWRUP - 1)) state <= ST_W_PR;
          else                                   pwrup_cnt <= pwrup_cnt + 1'b1;
        end
        ST_W_PR:  if (cmd == CMD_PR) state <= ST_W_AR0;
        ST_W_AR0: if (cmd == CMD_AR) state <= ST_W_AR1;
        ST_W_AR1: if (cmd == CMD_AR) state <= ST_W_LMR;
        ST_W_LMR: begin
          if (cmd == CMD_LMR) begin
            state     <= ST_READY;
            init_done <= 1'b1;
          end
        end
        ST_READY: begin
          if (cmd == CMD_ACT)     row_open <= 1'b1;
          else if (cmd == CMD_PR) row_open <= 1'b0;
        end
        default: state <= ST_PWRUP;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_cmd_checker.sv
// Directed bench for sdram_cmd_checker: stimulus queues expected output events, a
// negedge monitor pops and compares them, including the cycle they appear on.
module tb_sdram_cmd_checker;

  localparam int T_PWRUP = 13333;

  localparam logic [4:0] P_NOP  = 5'b10111;
  localparam logic [4:0] P_ACT  = 5'b10011;
  localparam logic [4:0] P_WR   = 5'b10100;
  localparam logic [4:0] P_RD   = 5'b10101;
  localparam logic [4:0] P_PR   = 5'b10010;
  localparam logic [4:0] P_AR   = 5'b10001;
  localparam logic [4:0] P_LMR  = 5'b10000;

  logic       sclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cke = 1'b1, cs = 1'b0, ras = 1'b1, cas = 1'b1, we = 1'b1;
  logic       cmd_vld, init_done, row_open, err_pulse, err_sticky;
  logic [2:0] cmd_code;
  logic [3:0] err_code;

  typedef struct {
    int         at;
    bit         vld;
    logic [2:0] code;
    bit         err;
    logic [3:0] ecode;
    bit         init;
    bit         row;
  } exp_t;

  exp_t       q[$];
  exp_t       mon_e;
  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;
  logic [3:0] m_sticky = '0;
  int         last_ar = 0;

  sdram_cmd_checker dut (
    .sclk(sclk), .rst_n(rst_n),
    .CKE(cke), .CS(cs), .RAS(ras), .CAS(cas), .WE(we),
    .cmd_vld(cmd_vld), .cmd_code(cmd_code), .init_done(init_done),
    .row_open(row_open), .err_pulse(err_pulse), .err_code(err_code),
    .err_sticky(err_sticky)
  );

  always #5 sclk = ~sclk;
  always @(posedge sclk) cyc <= cyc + 1;

  always @(negedge sclk) begin
    if (rst_n && (cmd_vld || err_pulse)) begin
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_event cyc=%0d got vld=%0b code=%0d err=%0b ecode=%0d, want no event",
                 cyc, cmd_vld, cmd_code, err_pulse, err_code);
      end else begin
        mon_e = q.pop_front();
        if (cyc != mon_e.at || cmd_vld != mon_e.vld || (mon_e.vld && cmd_code != mon_e.code) ||
            err_pulse != mon_e.err || err_code != mon_e.ecode ||
            err_sticky != (mon_e.ecode != 0) || init_done != mon_e.init || row_open != mon_e.row) begin
          miscompares++;
          $display("FAIL scoreboard got cyc=%0d vld=%0b code=%0d err=%0b ecode=%0d sticky=%0b init=%0b row=%0b; want cyc=%0d vld=%0b code=%0d err=%0b ecode=%0d init=%0b row=%0b",
                   cyc, cmd_vld, cmd_code, err_pulse, err_code, err_sticky, init_done, row_open,
                   mon_e.at, mon_e.vld, mon_e.code, mon_e.err, mon_e.ecode, mon_e.init, mon_e.row);
        end
      end
    end
  end

  task automatic step(input logic [4:0] p);
    @(posedge sclk);
    #1;
    {cke, cs, ras, cas, we} = p;
  endtask

  task automatic nop(input int n);
    repeat (n) step(P_NOP);
  endtask

  task automatic issue(input logic [4:0] p, input logic [2:0] code, input logic [3:0] err,
                       input bit row, input bit init);
    exp_t e;
    step(p);
    if (err != 0 && m_sticky == 0) m_sticky = err;
    e.at = cyc + 1; e.vld = 1'b1; e.code = code; e.err = (err != 0);
    e.ecode = m_sticky; e.init = init; e.row = row;
    q.push_back(e);
  endtask

  task automatic expect_err(input int at, input logic [3:0] err, input bit row);
    exp_t e;
    if (m_sticky == 0) m_sticky = err;
    e.at = at; e.vld = 1'b0; e.code = '0; e.err = 1'b1;
    e.ecode = m_sticky; e.init = 1'b1; e.row = row;
    q.push_back(e);
  endtask

  task automatic check_zero(input string name);
    vectors++;
    if ({cmd_vld, cmd_code, init_done, row_open, err_pulse, err_code, err_sticky} !== '0) begin
      miscompares++;
      $display("FAIL %s got vld=%0b code=%0d init=%0b row=%0b err=%0b ecode=%0d sticky=%0b, want all 0",
               name, cmd_vld, cmd_code, init_done, row_open, err_pulse, err_code, err_sticky);
    end
  endtask

  // Reset is dropped mid-cycle so the asynchronous clear is visible before any edge.
  task automatic reset_dut();
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL pending_before_reset got %0d queued events, want 0", q.size());
      q.delete();
    end
    @(posedge sclk);
    #3;
    rst_n = 1'b0;
    {cke, cs, ras, cas, we} = P_NOP;
    #1 check_zero("async_reset");
    m_sticky = '0;
    repeat (2) @(posedge sclk);
    @(negedge sclk) check_zero("reset_hold");
    @(posedge sclk);
    #1 rst_n = 1'b1;
  endtask

  // T_PWRUP NOP cycles (the first one is the release cycle), then PR/AR/AR/LMR.
  task automatic do_init();
    nop(T_PWRUP - 1);
    issue(P_PR, 3'd5, 4'd0, 1'b0, 1'b0);
    nop(3);
    issue(P_AR, 3'd6, 4'd0, 1'b0, 1'b0);
    nop(9);
    issue(P_AR, 3'd6, 4'd0, 1'b0, 1'b0);
    last_ar = cyc;
    nop(9);
    issue(P_LMR, 3'd7, 4'd0, 1'b0, 1'b1);
    nop(3);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog cyc=%0d, want completion before time limit", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] p;

    // PR long before power-up time has elapsed
    reset_dut();
    nop(98);
    issue(P_PR, 3'd5, 4'd1, 1'b0, 1'b0);
    nop(3);

    // clean init, then row/timing checks in READY
    reset_dut();
    do_init();
    issue(P_ACT, 3'd1, 4'd0, 1'b1, 1'b1);
    nop(1);
    issue(P_RD,  3'd3, 4'd4, 1'b1, 1'b1);
    nop(2);
    issue(P_WR,  3'd2, 4'd0, 1'b1, 1'b1);
    nop(2);
    issue(P_PR,  3'd5, 4'd8, 1'b0, 1'b1);
    nop(2);
    issue(P_ACT, 3'd1, 4'd0, 1'b1, 1'b1);
    nop(2);
    issue(P_RD,  3'd3, 4'd0, 1'b1, 1'b1);
    issue(P_WR,  3'd2, 4'd0, 1'b1, 1'b1);
    nop(4);
    issue(P_PR,  3'd5, 4'd0, 1'b0, 1'b1);
    nop(2);
    issue(P_RD,  3'd3, 4'd6, 1'b0, 1'b1);
    nop(2);
    issue(P_ACT, 3'd1, 4'd0, 1'b1, 1'b1);
    nop(1);
    issue(P_ACT, 3'd1, 4'd7, 1'b1, 1'b1);
    nop(2);
    issue(P_LMR, 3'd7, 4'd6, 1'b1, 1'b1);
    nop(1);
    issue(P_PR,  3'd5, 4'd0, 1'b0, 1'b1);
    nop(3);

    // AR -> ACT too soon, then tRP and tMRD violations
    reset_dut();
    do_init();
    issue(P_AR,  3'd6, 4'd0, 1'b0, 1'b1);
    nop(7);
    issue(P_ACT, 3'd1, 4'd3, 1'b1, 1'b1);
    nop(2);
    issue(P_PR,  3'd5, 4'd0, 1'b0, 1'b1);
    nop(1);
    issue(P_ACT, 3'd1, 4'd2, 1'b1, 1'b1);
    nop(2);
    issue(P_PR,  3'd5, 4'd0, 1'b0, 1'b1);
    nop(2);
    issue(P_LMR, 3'd7, 4'd0, 1'b0, 1'b1);
    issue(P_ACT, 3'd1, 4'd5, 1'b1, 1'b1);
    nop(3);

    // refresh interval: one pulse per missed window, re-armed by AR
    reset_dut();
    do_init();
    expect_err(last_ar + 1042, 4'd9, 1'b0);
    nop(1100);
    issue(P_AR, 3'd6, 4'd0, 1'b0, 1'b1);
    last_ar = cyc;
    expect_err(last_ar + 1042, 4'd9, 1'b0);
    nop(1200);

    // reset in the middle of an ACT/WR sequence, then a clean re-init
    issue(P_ACT, 3'd1, 4'd0, 1'b1, 1'b1);
    nop(2);
    issue(P_WR,  3'd2, 4'd0, 1'b1, 1'b1);
    nop(2);
    reset_dut();
    do_init();
    for (int i = 0; i < 20; i++) begin
      p = {1'b1, 1'b1, 3'($urandom_range(0, 7))};
      step(p);
    end
    for (int i = 0; i < 20; i++) begin
      p = {1'b0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7))};
      step(p);
    end
    nop(2);
    issue(P_AR,  3'd6, 4'd0, 1'b0, 1'b1);
    nop(9);
    issue(P_ACT, 3'd1, 4'd0, 1'b1, 1'b1);
    issue(P_PR,  3'd5, 4'd0, 1'b0, 1'b1);
    issue(P_RD,  3'd3, 4'd2, 1'b0, 1'b1);
    nop(4);

    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL leftover_events got %0d still queued, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
